// File: rtl/ofs_plat_prim_dc_pack_pkg.sv
// Shared definitions for the dual-clock FIFO packer/unpacker pair.
// The enqueue-side packer and the dequeue-side unpacker both decode the
// word header {last, cnt} that sits above the packed beats.
package ofs_plat_prim_dc_pack_pkg;

  // Header that sits above the beats in every packed word. The cnt field
  // is sized for any practical ratio; a word carries only its low
  // pack_cnt_w(ratio) bits.
  typedef struct packed {
    logic       last;
    logic [7:0] cnt;
  } t_pack_hdr;

  // Width of the beat-count field for a given pack ratio. It must hold
  // the full count (1..ratio), not just the slot index.
  function automatic int pack_cnt_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/ofs_plat_prim_fifo_dc_enq_packer.sv
// Enqueue-side packer for the dual-clock FIFO. Collects up to PACK_RATIO
// narrow beats into one wide word so that fewer entries cross the clock
// boundary. A partial word is closed early by in_last or by an idle timeout.
module ofs_plat_prim_fifo_dc_enq_packer
  import ofs_plat_prim_dc_pack_pkg::*;
#(
  parameter int N_IN_BITS      = 32,
  parameter int PACK_RATIO     = 4,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int CNT_W         = pack_cnt_w(PACK_RATIO),
  localparam int N_OUT_BITS    = PACK_RATIO * N_IN_BITS + CNT_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN_BITS-1:0]  in_data,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N_OUT_BITS-1:0] enq_data,
  output logic                  enq_en,
  input  logic                  notFull,
  input  logic                  almostFull
);

  localparam int BEATS_W = PACK_RATIO * N_IN_BITS;

  logic [BEATS_W-1:0]    packBeats_q, packBeats_d, beatsWithIn;
  logic [CNT_W-1:0]      packCnt_q, packCnt_d, cntWithIn;
  logic                  packClosed_q, packClosed_d;
  logic                  packLast_q, packLast_d;
  logic                  outValid_q, outValid_d;
  logic [N_OUT_BITS-1:0] outWord_q, outWord_d;

  logic accept;
  logic slotFree;
  logic closeBeat;
  logic timeoutFire;
  logic packClear;

  if (PACK_RATIO < 2) begin : g_bad_ratio
    $error("PACK_RATIO must be at least 2");
  end

  // The output register is emptied by the FIFO only when it has real room;
  // almostFull guards against the FIFO's own status lagging by a cycle.
  assign enq_en   = outValid_q && notFull && !almostFull && !reset;
  assign enq_data = outWord_q;
  assign in_ready = !packClosed_q && !reset;

  assign accept    = in_valid && in_ready;
  assign slotFree  = !outValid_q || enq_en;
  assign closeBeat = accept && (in_last || (packCnt_q == CNT_W'(PACK_RATIO - 1)));
  assign cntWithIn = packCnt_q + {{(CNT_W-1){1'b0}}, accept};

  // Pack contents as they would look with this cycle's beat dropped into slot cnt.
  always_comb begin
    beatsWithIn = packBeats_q;
    for (int k = 0; k < PACK_RATIO; k++) begin
      if (accept && (packCnt_q == CNT_W'(k))) begin
        beatsWithIn[k*N_IN_BITS +: N_IN_BITS] = in_data;
      end
    end
  end

  // Decide where a completed word goes: straight into the output register
  // when it is free this cycle, otherwise park it in the pack as closed.
  always_comb begin
    outValid_d   = outValid_q && !enq_en;
    outWord_d    = outWord_q;
    packBeats_d  = beatsWithIn;
    packCnt_d    = cntWithIn;
    packClosed_d = packClosed_q;
    packLast_d   = packLast_q;
    packClear    = 1'b0;

    if (packClosed_q) begin
      if (slotFree) begin
        outValid_d = 1'b1;
        outWord_d  = {packLast_q, packCnt_q, packBeats_q};
        packClear  = 1'b1;
      end
    end else if (closeBeat || timeoutFire) begin
      if (slotFree) begin
        outValid_d = 1'b1;
        outWord_d  = {closeBeat && in_last, cntWithIn, beatsWithIn};
        packClear  = 1'b1;
      end else begin
        packClosed_d = 1'b1;
        packLast_d   = closeBeat && in_last;
      end
    end

    if (packClear) begin
      packBeats_d  = '0;
      packCnt_d    = '0;
      packClosed_d = 1'b0;
      packLast_d   = 1'b0;
    end
  end

  // Pack and output registers; reset discards any partial or pending word.
  always_ff @(posedge clk) begin
    if (reset) begin
      packBeats_q  <= '0;
      packCnt_q    <= '0;
      packClosed_q <= 1'b0;
      packLast_q   <= 1'b0;
      outValid_q   <= 1'b0;
      outWord_q    <= '0;
    end else begin
      packBeats_q  <= packBeats_d;
      packCnt_q    <= packCnt_d;
      packClosed_q <= packClosed_d;
      packLast_q   <= packLast_d;
      outValid_q   <= outValid_d;
      outWord_q    <= outWord_d;
    end
  end

  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);

    logic [IDLE_W-1:0] idle_q, idle_d, idleInc;
    logic              idling;

    // A partial, still-open word with no new beat this cycle is aging.
    assign idling      = (packCnt_q != '0) && !packClosed_q && !accept;
    assign idleInc     = idle_q + 1'b1;
    assign timeoutFire = idling && (idleInc == IDLE_LIMIT);

    // Restart the idle count whenever the pack grows or empties.
    always_comb begin
      idle_d = idle_q;
      if (accept || packClear) begin
        idle_d = '0;
      end else if (idling) begin
        idle_d = idleInc;
      end
    end

    // Idle counter register.
    always_ff @(posedge clk) begin
      if (reset) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_d;
      end
    end
  end else begin : g_no_timeout
    assign timeoutFire = 1'b0;
  end

  a_no_enq_when_full: assert property (@(posedge clk) disable iff (reset) !(enq_en && !notFull))
    else $error("enq_en asserted while FIFO reports full");

endmodule
